// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU request at a time, drives the external ALU
// with one-hot controls for a fixed number of EXEC cycles, then captures and
// holds the ALU result until the consumer takes it.
// Optional divide support is compiled in with the ALU_SEQ_DIV_EN macro; without
// it opcode 9 is rejected as illegal like opcodes 12-15.
module alu_op_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  opcode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [11:0] alu_ctrl,
    output logic [31:0] alu_ra,
    output logic [31:0] alu_rb,
    input  logic [31:0] alu_zhi,
    input  logic [31:0] alu_zlo,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        illegal
);

    // Both cycle counts must fit the 4-bit EXEC counter.
    if (MUL_CYCLES < 1 || MUL_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cycles
        $error("alu_op_sequencer: MUL_CYCLES and DIV_CYCLES must lie in 1..15");
    end

    localparam logic [3:0] MulLast = 4'(MUL_CYCLES - 1);
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] DivLast = 4'(DIV_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] ra_q, ra_d;
    logic [31:0] rb_q, rb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        illegal_q, illegal_d;

    logic        op_legal;
    logic [3:0]  op_last;

    // Classify the incoming opcode and pick its EXEC length minus one.
    always_comb begin
        op_legal = 1'b0;
        op_last  = 4'd0;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11: begin
                op_legal = 1'b1;
            end
            4'd8: begin
                op_legal = 1'b1;
                op_last  = MulLast;
            end
`ifdef ALU_SEQ_DIV_EN
            4'd9: begin
                op_legal = 1'b1;
                op_last  = DivLast;
            end
`endif
            default: begin
                op_legal = 1'b0;
            end
        endcase
    end

    // Next-state logic: accept/reject in IDLE, count down in EXEC, hand off in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        illegal_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    if (op_legal) begin
                        op_d    = opcode;
                        ra_d    = op_a;
                        rb_d    = op_b;
                        cnt_d   = op_last;
                        state_d = StExec;
                    end else begin
                        // Rejected request is still consumed; flag it next cycle.
                        illegal_d = 1'b1;
                    end
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    hi_d    = alu_zhi;
                    lo_d    = alu_zlo;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // Always pass through IDLE before the next accept.
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; clear discards any operation in flight.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            op_q      <= 4'd0;
            ra_q      <= 32'd0;
            rb_q      <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            illegal_q <= illegal_d;
        end
    end

    // One-hot ALU control, only while executing.
    always_comb begin
        alu_ctrl = 12'h000;
        if (state_q == StExec) begin
            case (op_q)
                4'd0:    alu_ctrl = 12'h001;
                4'd1:    alu_ctrl = 12'h002;
                4'd2:    alu_ctrl = 12'h004;
                4'd3:    alu_ctrl = 12'h008;
                4'd4:    alu_ctrl = 12'h010;
                4'd5:    alu_ctrl = 12'h020;
                4'd6:    alu_ctrl = 12'h040;
                4'd7:    alu_ctrl = 12'h080;
                4'd8:    alu_ctrl = 12'h100;
`ifdef ALU_SEQ_DIV_EN
                4'd9:    alu_ctrl = 12'h200;
`endif
                4'd10:   alu_ctrl = 12'h400;
                4'd11:   alu_ctrl = 12'h800;
                default: alu_ctrl = 12'h000;
            endcase
        end
    end

    // Handshake and data outputs; op_ready stays low while clear is held.
    always_comb begin
        op_ready  = (state_q == StIdle) && !clear;
        res_valid = (state_q == StDone);
        alu_ra    = ra_q;
        alu_rb    = rb_q;
        res_hi    = hi_q;
        res_lo    = lo_q;
        illegal   = illegal_q;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, hand-written corner
// sequences (backpressure, clear mid-EXEC) and randomized requests checked
// against an opcode-level reference model. Includes a behavioural ALU.
module tb_alu_op_sequencer;

    localparam int unsigned MulCycles = 4;
    localparam int unsigned DivCycles = 8;
`ifdef ALU_SEQ_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        op_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        op_ready, res_valid, illegal;
    logic [11:0] alu_ctrl;
    logic [31:0] alu_ra, alu_rb, alu_zhi, alu_zlo, res_hi, res_lo;

    alu_op_sequencer #(
        .MUL_CYCLES(MulCycles),
        .DIV_CYCLES(DivCycles)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .opcode   (opcode),
        .op_a     (op_a),
        .op_b     (op_b),
        .alu_ctrl (alu_ctrl),
        .alu_ra   (alu_ra),
        .alu_rb   (alu_rb),
        .alu_zhi  (alu_zhi),
        .alu_zlo  (alu_zlo),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference ALU behaviour per opcode; {hi, lo}. Multiply/divide are signed.
    function automatic logic [63:0] alu_fn(input logic [3:0] opc, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] dbl;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (opc)
            4'd0:  return {32'd0, a + b};
            4'd1:  return {32'd0, a - b};
            4'd2:  return {32'd0, a >> b[4:0]};
            4'd3:  return {32'd0, a << b[4:0]};
            4'd4: begin
                dbl = {a, a} >> b[4:0];
                return {32'd0, dbl[31:0]};
            end
            4'd5: begin
                dbl = {a, a} << b[4:0];
                return {32'd0, dbl[63:32]};
            end
            4'd6:  return {32'd0, a & b};
            4'd7:  return {32'd0, a | b};
            4'd8:  return sa * sb;
            4'd9: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd10: return {32'd0, -a};
            4'd11: return {32'd0, ~a};
            default: return 64'd0;
        endcase
    endfunction

    // Behavioural ALU driven by whichever control bit is set.
    always_comb begin
        logic [63:0] z;
        z = 64'd0;
        for (int k = 0; k < 12; k++) begin
            if (alu_ctrl == (12'h001 << k)) z = alu_fn(4'(k), alu_ra, alu_rb);
        end
        alu_zhi = z[63:32];
        alu_zlo = z[31:0];
    end

    // alu_ctrl[9] must never appear in a build without divide.
    logic saw_div_ctrl = 1'b0;
    always @(negedge clock) if (alu_ctrl[9]) saw_div_ctrl <= 1'b1;

    function automatic bit legal_m(input logic [3:0] opc);
        return (opc <= 4'd11) && (opc != 4'd9 || DivEn);
    endfunction

    function automatic int cycles_m(input logic [3:0] opc);
        if (opc == 4'd8) return MulCycles;
        if (opc == 4'd9) return DivCycles;
        return 1;
    endfunction

    // Observations from one request.
    logic [11:0] r_ctrl_or;
    int          r_cycles, r_lat;
    logic        r_onehot, r_ill0, r_ill1;
    logic [31:0] r_ra, r_rb;

    // Present one request at a negedge, then watch up to 20 cycles. Returns at
    // the negedge where res_valid is first seen (r_lat = edges since accept).
    task automatic run_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        opcode   = opc;
        op_a     = a;
        op_b     = b;
        @(posedge clock);
        @(negedge clock);
        op_valid  = 1'b0;
        opcode    = 4'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        r_ctrl_or = 12'h000;
        r_cycles  = 0;
        r_lat     = -1;
        r_onehot  = 1'b1;
        r_ill0    = 1'b0;
        r_ill1    = 1'b0;
        r_ra      = 32'd0;
        r_rb      = 32'd0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) r_ill0 = illegal;
            if (i == 1) r_ill1 = illegal;
            if (res_valid) begin
                r_lat = i;
                break;
            end
            if (alu_ctrl != 12'h000) begin
                r_cycles++;
                r_ctrl_or |= alu_ctrl;
                if (!$onehot(alu_ctrl)) r_onehot = 1'b0;
                r_ra = alu_ra;
                r_rb = alu_rb;
            end
            @(negedge clock);
        end
    endtask

    // Hold the result for 'hold' cycles, then take it.
    task automatic take_result(input string tag, input int hold, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, " held res_valid"}, 64'(res_valid), 64'd1);
            check({tag, " held res"}, {res_hi, res_lo}, {exp_hi, exp_lo});
            check({tag, " held op_ready"}, 64'(op_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        res_ready = 1'b0;
        check({tag, " after take res_valid"}, 64'(res_valid), 64'd0);
        check({tag, " after take op_ready"}, 64'(op_ready), 64'd1);
        check({tag, " after take res kept"}, {res_hi, res_lo}, {exp_hi, exp_lo});
    endtask

    // Compare one request's observations with expectations.
    task automatic check_op(input string tag, input logic [3:0] opc, input logic [31:0] a,
                            input logic [31:0] b, input logic [11:0] e_ctrl, input int e_cyc,
                            input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_ill);
        check({tag, " op_ready idle"}, 64'(op_ready), 64'd1);
        run_op(opc, a, b);
        check({tag, " alu_ctrl"}, 64'(r_ctrl_or), 64'(e_ctrl));
        check({tag, " ctrl cycles"}, 64'(r_cycles), 64'(e_cyc));
        check({tag, " ctrl onehot"}, 64'(r_onehot), 64'd1);
        check({tag, " latency"}, 64'(r_lat), e_ill ? 64'(-1) : 64'(e_cyc));
        check({tag, " illegal pulse"}, {62'd0, r_ill0, r_ill1}, e_ill ? 64'd2 : 64'd0);
        check({tag, " result"}, {res_hi, res_lo}, {e_hi, e_lo});
        if (!e_ill) begin
            check({tag, " operands"}, {r_ra, r_rb}, {a, b});
        end
    endtask

    typedef struct {
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [11:0] ctrl;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill;
    } vec_t;

    initial begin
        vec_t vecs[$];
        logic [31:0] last_hi, last_lo;
        bit saw_res;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] last_hi, last_lo, a, b;
        logic [3:0] opc;
        logic [63:0] z;
        bit saw_res;
        int cyc;

        vecs.push_back('{4'd0,  32'd5,          32'd7,          12'h001, 1, 32'd0,          32'd12,         1'b0});
        vecs.push_back('{4'd8,  32'hFFFF_FFFF,  32'd2,          12'h100, 4, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0});
        vecs.push_back('{4'd2,  32'h8000_0000,  32'd4,          12'h004, 1, 32'd0,          32'h0800_0000,  1'b0});
        vecs.push_back('{4'd3,  32'd1,          32'd31,         12'h008, 1, 32'd0,          32'h8000_0000,  1'b0});
        vecs.push_back('{4'd4,  32'd1,          32'd1,          12'h010, 1, 32'd0,          32'h8000_0000,  1'b0});
        vecs.push_back('{4'd5,  32'h8000_0000,  32'd1,          12'h020, 1, 32'd0,          32'd1,          1'b0});
        vecs.push_back('{4'd6,  32'h0000_F0F0,  32'h0000_FF00,  12'h040, 1, 32'd0,          32'h0000_F000,  1'b0});
        vecs.push_back('{4'd7,  32'h0000_F0F0,  32'h0000_0F0F,  12'h080, 1, 32'd0,          32'h0000_FFFF,  1'b0});
        vecs.push_back('{4'd10, 32'd1,          32'd0,          12'h400, 1, 32'd0,          32'hFFFF_FFFF,  1'b0});
        vecs.push_back('{4'd11, 32'h0F0F_0F0F,  32'd0,          12'h800, 1, 32'd0,          32'hF0F0_F0F0,  1'b0});
        // Rejected opcodes leave the previous result in place.
        vecs.push_back('{4'd13, 32'd3,          32'd4,          12'h000, 0, 32'd0,          32'hF0F0_F0F0,  1'b1});
        vecs.push_back('{4'd15, 32'd3,          32'd4,          12'h000, 0, 32'd0,          32'hF0F0_F0F0,  1'b1});
`ifdef ALU_SEQ_DIV_EN
        vecs.push_back('{4'd9,  32'd100,        32'd7,          12'h200, 8, 32'd2,          32'd14,         1'b0});
`else
        vecs.push_back('{4'd9,  32'd100,        32'd7,          12'h000, 0, 32'd0,          32'hF0F0_F0F0,  1'b1});
`endif

        // Reset state while clear is held.
        @(negedge clock);
        check("reset res_valid", 64'(res_valid), 64'd0);
        check("reset alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("reset operands", {alu_ra, alu_rb}, 64'd0);
        check("reset result", {res_hi, res_lo}, 64'd0);
        check("reset illegal", 64'(illegal), 64'd0);
        check("reset op_ready", 64'(op_ready), 64'd0);
        clear = 1'b0;
        @(negedge clock);
        check("post-reset op_ready", 64'(op_ready), 64'd1);

        // Directed vector table.
        foreach (vecs[i]) begin
            check_op($sformatf("vec%0d", i), vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].ctrl,
                     vecs[i].cyc, vecs[i].hi, vecs[i].lo, vecs[i].ill);
            if (!vecs[i].ill) take_result($sformatf("vec%0d", i), 0, vecs[i].hi, vecs[i].lo);
            else @(negedge clock);
        end

        // Backpressure on sub 9-4 with competing requests, then a request held
        // across the DONE->IDLE edge must not be accepted on that edge.
        run_op(4'd1, 32'd9, 32'd4);
        check("bp latency", 64'(r_lat), 64'd1);
        op_valid = 1'b1;
        opcode   = 4'd0;
        op_a     = 32'd77;
        op_b     = 32'd88;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp res_valid", 64'(res_valid), 64'd1);
            check("bp res_lo", 64'(res_lo), 64'd5);
            check("bp op_ready", 64'(op_ready), 64'd0);
            check("bp operands", {alu_ra, alu_rb}, {32'd9, 32'd4});
        end
        res_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        res_ready = 1'b0;
        op_valid  = 1'b0;
        check("bp idle gap op_ready", 64'(op_ready), 64'd1);
        check("bp idle gap alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("bp idle gap operands", {alu_ra, alu_rb}, {32'd9, 32'd4});
        check("bp result kept", {res_hi, res_lo}, {32'd0, 32'd5});

        // Clear in the 3rd EXEC cycle of a long operation.
        opc = DivEn ? 4'd9 : 4'd8;
        op_valid = 1'b1;
        opcode   = opc;
        op_a     = 32'd300;
        op_b     = 32'd7;
        @(posedge clock);
        @(negedge clock);
        op_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("clr exec ctrl", 64'(alu_ctrl), 64'(12'h001 << opc));
        clear = 1'b1;
        #1;
        check("clr alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("clr operands", {alu_ra, alu_rb}, 64'd0);
        check("clr result", {res_hi, res_lo}, 64'd0);
        check("clr res_valid", 64'(res_valid), 64'd0);
        check("clr illegal", 64'(illegal), 64'd0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        check("clr release op_ready", 64'(op_ready), 64'd1);
        saw_res = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid) saw_res = 1'b1;
            @(negedge clock);
        end
        check("clr no result", 64'(saw_res), 64'd0);
        check("clr result stays 0", {res_hi, res_lo}, 64'd0);

        // Randomized requests against the opcode-level model.
        last_hi = 32'd0;
        last_lo = 32'd0;
        for (int n = 0; n < 40; n++) begin
            opc = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (legal_m(opc)) begin
                z   = alu_fn(opc, a, b);
                cyc = cycles_m(opc);
                check_op($sformatf("rnd%0d", n), opc, a, b, 12'h001 << opc, cyc, z[63:32],
                         z[31:0], 1'b0);
                last_hi = z[63:32];
                last_lo = z[31:0];
                take_result($sformatf("rnd%0d", n), $urandom_range(0, 3), last_hi, last_lo);
            end else begin
                check_op($sformatf("rnd%0d", n), opc, a, b, 12'h000, 0, last_hi, last_lo, 1'b1);
                @(negedge clock);
            end
        end

`ifndef ALU_SEQ_DIV_EN
        check("div ctrl never set", 64'(saw_div_ctrl), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
